// File: rtl/eth_pcs_64_66_encoder_pkg.sv
// Shared 10GBASE-R PCS constants, TX state/class types and the TX state transition rule.
package eth_pcs_params;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BLK_TYPE_C  = 8'h1E;
  localparam logic [7:0] BLK_TYPE_S0 = 8'h78;
  localparam logic [7:0] BLK_TYPE_S4 = 8'h33;
  localparam logic [7:0] BLK_TYPE_T0 = 8'h87;
  localparam logic [7:0] BLK_TYPE_T1 = 8'h99;
  localparam logic [7:0] BLK_TYPE_T2 = 8'hAA;
  localparam logic [7:0] BLK_TYPE_T3 = 8'hB4;
  localparam logic [7:0] BLK_TYPE_T4 = 8'hCC;
  localparam logic [7:0] BLK_TYPE_T5 = 8'hD2;
  localparam logic [7:0] BLK_TYPE_T6 = 8'hE1;
  localparam logic [7:0] BLK_TYPE_T7 = 8'hFF;
  localparam logic [7:0] OS_TYPE     = 8'h4B;

  localparam logic [7:0] SYM_IDLE  = 8'h07;
  localparam logic [7:0] SYM_START = 8'hFB;
  localparam logic [7:0] SYM_TERM  = 8'hFD;
  localparam logic [7:0] SYM_ERR   = 8'hFE;

  localparam logic [6:0] CODE_IDLE = 7'h00;
  localparam logic [6:0] CODE_ERR  = 7'h1E;

  localparam logic [63:0] ERR_PAYLOAD = {{8{CODE_ERR}}, BLK_TYPE_C};

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
  typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_t;

  function automatic logic [7:0] term_type(input int unsigned k);
    logic [7:0] t;
    case (k)
      0:       t = BLK_TYPE_T0;
      1:       t = BLK_TYPE_T1;
      2:       t = BLK_TYPE_T2;
      3:       t = BLK_TYPE_T3;
      4:       t = BLK_TYPE_T4;
      5:       t = BLK_TYPE_T5;
      6:       t = BLK_TYPE_T6;
      default: t = BLK_TYPE_T7;
    endcase
    return t;
  endfunction

  function automatic tx_state_t tx_next(input tx_state_t s, input blk_class_t c);
    tx_state_t n;
    n = TX_E;
    case (s)
      TX_D: begin
        if (c == BLK_D)      n = TX_D;
        else if (c == BLK_T) n = TX_T;
      end
      TX_E: begin
        case (c)
          BLK_C:   n = TX_C;
          BLK_D:   n = TX_D;
          BLK_T:   n = TX_T;
          BLK_S:   n = TX_D;
          default: n = TX_E;
        endcase
      end
      default: begin
        if (c == BLK_C)      n = TX_C;
        else if (c == BLK_S) n = TX_D;
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/eth_pcs_64_66_blk_classify.sv
// Combinational 64b/66b block classification and payload construction for one 8-lane XGMII block.
module eth_pcs_64_66_blk_classify
  import eth_pcs_params::*;
(
  input  logic [7:0]  ctrl,
  input  logic [63:0] data,
  output blk_class_t  cls,
  output logic [63:0] payload
);

  logic [7:0]  is_idle;
  logic [7:0]  is_term;
  logic [7:0]  ctrl_mask;
  logic [7:0]  idle_mask;
  logic [55:0] keep;

  always_comb begin
    is_idle = '0;
    is_term = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      is_idle[i] = (data[8*i +: 8] == SYM_IDLE);
      is_term[i] = (data[8*i +: 8] == SYM_TERM);
    end
  end

  always_comb begin
    cls       = BLK_E;
    payload   = '0;
    ctrl_mask = '0;
    idle_mask = '0;
    keep      = '0;
    if (ctrl == 8'h00) begin
      cls     = BLK_D;
      payload = data;
    end else if (ctrl == 8'hFF && is_idle == 8'hFF) begin
      cls     = BLK_C;
      payload = {56'h0, BLK_TYPE_C};
    end else if (ctrl == 8'h01 && data[7:0] == SYM_START) begin
      cls     = BLK_S;
      payload = {data[63:8], BLK_TYPE_S0};
    end else if (ctrl == 8'h1F && is_idle[3:0] == 4'hF && data[39:32] == SYM_START) begin
      cls     = BLK_S;
      payload = {data[63:40], 32'h0, BLK_TYPE_S4};
    end else begin
      // Tk: lanes below k are data, lane k is /T/, every lane above k is idle control
      for (int unsigned k = 0; k < 8; k++) begin
        ctrl_mask = 8'hFF << k;
        idle_mask = ctrl_mask << 1;
        if (ctrl == ctrl_mask && is_term[k] && (is_idle & idle_mask) == idle_mask) begin
          cls  = BLK_T;
          keep = '0;
          for (int unsigned j = 0; j < 7; j++) begin
            if (j < k) keep[8*j +: 8] = '1;
          end
          payload = {data[55:0] & keep, term_type(k)};
        end
      end
    end
  end

endmodule

// File: rtl/eth_pcs_64_66_encoder.sv
// 10GBASE-R TX 64b/66b encoder: pairs 32-bit XGMII transfers, encodes, runs the TX state machine.
module eth_pcs_64_66_encoder
  import eth_pcs_params::*;
#(
  parameter int unsigned ENC_OUT_REG = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  input  logic [3:0]  i_xgmii_ctrl,
  input  logic [31:0] i_xgmii_data,
  output logic        o_hdr_valid,
  output logic [1:0]  o_hdr,
  output logic [31:0] o_data,
  output logic        o_blk_err
);

  logic        in_cnt;
  logic [3:0]  lo_ctrl;
  logic [31:0] lo_data;
  tx_state_t   state;
  tx_state_t   state_nxt;
  blk_class_t  cls;
  logic [63:0] cls_payload;
  logic        enc_err;
  logic [1:0]  enc_hdr;
  logic [63:0] enc_payload;
  logic [31:0] hi_q;
  logic [1:0]  blk_hdr;

  eth_pcs_64_66_blk_classify u_classify (
    .ctrl    ({i_xgmii_ctrl, lo_ctrl}),
    .data    ({i_xgmii_data, lo_data}),
    .cls     (cls),
    .payload (cls_payload)
  );

  always_comb begin
    state_nxt   = tx_next(state, cls);
    enc_err     = (state_nxt == TX_E);
    enc_hdr     = (!enc_err && cls == BLK_D) ? SYNC_DATA : SYNC_CTRL;
    enc_payload = enc_err ? ERR_PAYLOAD : cls_payload;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      in_cnt  <= 1'b0;
      lo_ctrl <= '0;
      lo_data <= '0;
      state   <= TX_INIT;
      hi_q    <= '0;
      blk_hdr <= SYNC_CTRL;
    end else if (i_clk_en) begin
      in_cnt <= ~in_cnt;
      if (!in_cnt) begin
        lo_ctrl <= i_xgmii_ctrl;
        lo_data <= i_xgmii_data;
      end else begin
        state   <= state_nxt;
        blk_hdr <= enc_hdr;
        hi_q    <= enc_payload[63:32];
      end
    end
  end

  if (ENC_OUT_REG != 0) begin : g_out_reg
    logic        out_cnt;
    logic [31:0] data_q;
    logic        err_q;

    // Low half is loaded straight from the encoder so it leaves one cycle after the block completes;
    // the high half follows from hi_q. Reset shows the low half of an idle C block.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        out_cnt <= 1'b0;
        data_q  <= {24'h0, BLK_TYPE_C};
        err_q   <= 1'b0;
      end else if (i_clk_en) begin
        out_cnt <= ~out_cnt;
        if (in_cnt) begin
          data_q <= enc_payload[31:0];
          err_q  <= enc_err;
        end else begin
          data_q <= hi_q;
          err_q  <= 1'b0;
        end
      end
    end

    assign o_hdr_valid = ~out_cnt;
    assign o_hdr       = blk_hdr;
    assign o_data      = data_q;
    assign o_blk_err   = err_q & i_clk_en;
  end else begin : g_out_comb
    assign o_hdr_valid = in_cnt;
    assign o_hdr       = in_cnt ? enc_hdr : blk_hdr;
    assign o_data      = in_cnt ? enc_payload[31:0] : hi_q;
    assign o_blk_err   = in_cnt & enc_err & i_clk_en;
  end

endmodule

// File: tb/tb_eth_pcs_64_66_encoder.sv
// Scoreboard bench for eth_pcs_64_66_encoder against a lane-level reference of the 64b/66b TX rules.
module tb_eth_pcs_64_66_encoder;

  localparam int ST_INIT = 0, ST_C = 1, ST_D = 2, ST_T = 3, ST_E = 4;
  localparam int K_C = 0, K_S = 1, K_D = 2, K_T = 3, K_E = 4;

  typedef struct packed {
    logic        hv;
    logic [1:0]  hdr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [3:0]  ctrl;
  logic [31:0] data;
  logic        hv;
  logic [1:0]  hdr;
  logic [31:0] odata;
  logic        blk_err;

  exp_t        sb[$];
  exp_t        last_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_on = 1'b0;
  int          m_state = ST_INIT;
  logic [63:0] err_payload;
  logic [7:0]  t_type [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  // rows: current state INIT,C,D,T,E; columns: block kind C,S,D,T,E
  int          nxt_tbl [5][5] = '{'{1, 2, 4, 4, 4}, '{1, 2, 4, 4, 4}, '{4, 4, 2, 3, 4},
                                  '{1, 2, 4, 4, 4}, '{1, 2, 2, 3, 4}};

  always #5 clk = ~clk;

  eth_pcs_64_66_encoder #(.ENC_OUT_REG(1)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_clk_en     (clk_en),
    .i_xgmii_ctrl (ctrl),
    .i_xgmii_data (data),
    .o_hdr_valid  (hv),
    .o_hdr        (hdr),
    .o_data       (odata),
    .o_blk_err    (blk_err)
  );

  function automatic exp_t mk(input bit v, input logic [1:0] h, input logic [31:0] d, input bit e);
    exp_t r;
    r.hv = v; r.hdr = h; r.data = d; r.err = e;
    return r;
  endfunction

  function automatic int classify_ref(input logic [7:0] c, input logic [63:0] d, output logic [63:0] p);
    logic [7:0] b [8];
    int n;
    bit ok;
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    p = '0;
    if (c == 8'h00) begin
      p = d;
      return K_D;
    end
    if (c == 8'hFF) begin
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (b[i] != 8'h07) ok = 1'b0;
      if (ok) begin
        p = 64'h1E;
        return K_C;
      end
    end
    if (c == 8'h01 && b[0] == 8'hFB) begin
      p = d;
      p[7:0] = 8'h78;
      return K_S;
    end
    if (c == 8'h1F && b[0] == 8'h07 && b[1] == 8'h07 && b[2] == 8'h07 && b[3] == 8'h07 && b[4] == 8'hFB) begin
      p[7:0] = 8'h33;
      p[63:40] = d[63:40];
      return K_S;
    end
    n = 0;
    while (n < 8 && !c[n]) n++;
    if (n < 8 && b[n] == 8'hFD) begin
      ok = 1'b1;
      for (int i = n + 1; i < 8; i++) if (!c[i] || b[i] != 8'h07) ok = 1'b0;
      if (ok) begin
        p[7:0] = t_type[n];
        for (int j = 0; j < n; j++) p[8 + 8*j +: 8] = b[j];
        return K_T;
      end
    end
    return K_E;
  endfunction

  task automatic model_step(input logic [7:0] c, input logic [63:0] d, output exp_t lo, output exp_t hi);
    logic [63:0] p;
    logic [1:0] h;
    int k;
    bit e;
    k = classify_ref(c, d, p);
    m_state = nxt_tbl[m_state][k];
    e = (m_state == ST_E);
    if (e) p = err_payload;
    h = (!e && k == K_D) ? 2'b01 : 2'b10;
    lo = mk(1'b1, h, p[31:0], e);
    hi = mk(1'b0, h, p[63:32], 1'b0);
  endtask

  task automatic check_out(input string name, input exp_t e);
    n_checks++;
    if (hv !== e.hv || odata !== e.data || blk_err !== e.err || (e.hv && hdr !== e.hdr)) begin
      n_errors++;
      $display("FAIL %s: got hv=%0b hdr=%b data=%h err=%0b, want hv=%0b hdr=%b data=%h err=%0b",
               name, hv, hdr, odata, blk_err, e.hv, e.hdr, e.data, e.err);
    end
  endtask

  task automatic half(input logic [3:0] c, input logic [31:0] d, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      clk_en = 1'b0;
      ctrl = 4'($urandom);
      data = $urandom;
    end
    @(negedge clk);
    clk_en = 1'b1;
    ctrl = c;
    data = d;
  endtask

  task automatic send(input logic [7:0] c, input logic [63:0] d, input int s1, input int s2);
    exp_t lo, hi;
    half(c[3:0], d[31:0], s1);
    half(c[7:4], d[63:32], s2);
    model_step(c, d, lo, hi);
    sb.push_back(lo);
    sb.push_back(hi);
  endtask

  task automatic send_exp(input logic [7:0] c, input logic [63:0] d, input int s1, input int s2,
                          input exp_t lo, input exp_t hi);
    exp_t ml, mh;
    half(c[3:0], d[31:0], s1);
    half(c[7:4], d[63:32], s2);
    model_step(c, d, ml, mh);
    sb.push_back(lo);
    sb.push_back(hi);
  endtask

  function automatic void term_block(input int k, output logic [7:0] c, output logic [63:0] d);
    d = {$urandom, $urandom};
    c = 8'hFF << k;
    d[8*k +: 8] = 8'hFD;
    for (int i = k + 1; i < 8; i++) d[8*i +: 8] = 8'h07;
  endfunction

  function automatic void gen_block(input int st, output logic [7:0] c, output logic [63:0] d);
    int r;
    int k;
    d = {$urandom, $urandom};
    c = 8'h00;
    r = (st == ST_D && $urandom_range(0, 2) != 0) ? $urandom_range(4, 7) : $urandom_range(0, 9);
    case (r)
      0, 1: begin c = 8'hFF; d = {8{8'h07}}; end
      2:    begin c = 8'h01; d[7:0] = 8'hFB; end
      3:    begin c = 8'h1F; d[39:0] = {8'hFB, 32'h07070707}; end
      4, 5: c = 8'h00;
      6, 7: begin k = $urandom_range(0, 7); term_block(k, c, d); end
      8:    begin c = 8'($urandom); d[15:8] = 8'hFE; end
      default: begin
        k = $urandom_range(0, 7);
        term_block(k, c, d);
        if (k < 7) d[8*(k+1) +: 8] = 8'h9C;
        else d[63:56] = 8'hFE;
      end
    endcase
  endfunction

  always @(posedge clk) begin : monitor
    bit en_s;
    exp_t e;
    en_s = clk_en;
    #1;
    if (mon_on && rst_n) begin
      if (en_s) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got data=%h with no expected entry, want an entry", odata);
        end else begin
          e = sb.pop_front();
          last_exp = e;
          check_out("stream", e);
        end
      end else begin
        e = last_exp;
        e.err = 1'b0;
        check_out("stall_hold", e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of run, want $finish before time limit");
    $fatal(1);
  end

  initial begin : main
    exp_t idle_lo, idle_hi, err_lo, err_hi;
    logic [7:0] c;
    logic [63:0] d;
    int s1, s2;

    err_payload = 64'h1E;
    for (int i = 0; i < 8; i++) err_payload[8 + 7*i +: 7] = 7'h1E;
    idle_lo = mk(1'b1, 2'b10, 32'h0000001E, 1'b0);
    idle_hi = mk(1'b0, 2'b10, 32'h00000000, 1'b0);
    err_lo  = mk(1'b1, 2'b10, err_payload[31:0], 1'b1);
    err_hi  = mk(1'b0, 2'b10, err_payload[63:32], 1'b0);

    rst_n = 1'b0; clk_en = 1'b0; ctrl = '0; data = '0;
    #12;
    check_out("reset_value", idle_lo);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = idle_lo;
    sb.push_back(idle_hi);
    mon_on = 1'b1;

    repeat (3) send_exp(8'hFF, {8{8'h07}}, 0, 0, idle_lo, idle_hi);
    send_exp(8'h01, 64'hD5555555_555555FB, 0, 0, mk(1, 2'b10, 32'h55555578, 0), mk(0, 2'b10, 32'hD5555555, 0));
    send_exp(8'h00, 64'h01234567_89ABCDEF, 0, 0, mk(1, 2'b01, 32'h89ABCDEF, 0), mk(0, 2'b01, 32'h01234567, 0));
    send_exp(8'hF8, 64'h07070707_FDCCBBAA, 0, 0, mk(1, 2'b10, 32'hCCBBAAB4, 0), idle_hi);

    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom};
      d[7:0] = 8'hFB;
      send(8'h01, d, 0, 0);
      send(8'h00, {$urandom, $urandom}, 0, 0);
      term_block(k, c, d);
      send(c, d, 0, 0);
    end

    send_exp(8'hFF, {8{8'h07}}, 0, 0, idle_lo, idle_hi);
    send_exp(8'h00, {$urandom, $urandom}, 0, 0, err_lo, err_hi);
    send_exp(8'hFF, {8{8'h07}}, 0, 0, idle_lo, idle_hi);
    send_exp(8'h1F, 64'h112233FB_07070707, 0, 0, mk(1, 2'b10, 32'h00000033, 0), mk(0, 2'b10, 32'h11223300, 0));
    send_exp(8'hFF, 64'h07070707_070707FD, 0, 0, mk(1, 2'b10, 32'h00000087, 0), idle_hi);

    send_exp(8'h01, 64'hD5555555_555555FB, 0, 3, mk(1, 2'b10, 32'h55555578, 0), mk(0, 2'b10, 32'hD5555555, 0));
    send_exp(8'h00, 64'h01234567_89ABCDEF, 3, 0, mk(1, 2'b01, 32'h89ABCDEF, 0), mk(0, 2'b01, 32'h01234567, 0));
    send_exp(8'hF8, 64'h07070707_FDCCBBAA, 3, 3, mk(1, 2'b10, 32'hCCBBAAB4, 0), idle_hi);
    send_exp(8'h00, {$urandom, $urandom}, 3, 0, err_lo, err_hi);
    send_exp(8'hFF, {8{8'h07}}, 2, 0, idle_lo, idle_hi);

    for (int n = 0; n < 300; n++) begin
      gen_block(m_state, c, d);
      s1 = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      s2 = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      send(c, d, s1, s2);
    end

    half(4'h1, 32'h555555FB, 0);
    @(posedge clk);
    #3;
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_out("reset_mid_block", idle_lo);
    sb.delete();
    m_state = ST_INIT;
    @(negedge clk);
    clk_en = 1'b0;
    ctrl = 4'hF;
    data = 32'h07070707;
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = idle_lo;
    sb.push_back(idle_hi);
    mon_on = 1'b1;
    repeat (2) send_exp(8'hFF, {8{8'h07}}, 0, 0, idle_lo, idle_hi);
    send_exp(8'h00, {$urandom, $urandom}, 0, 0, err_lo, err_hi);

    @(posedge clk);
    #2;
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_pcs_64_66_encoder.md
Name: eth_pcs_64_66_encoder

Overview:
TX-side 64b/66b block encoder of the 10GBASE-R PCS. Collects two 32-bit XGMII transfers from the MAC TX into one 64-bit block, classifies and encodes it per Clause 49, and runs the Clause 49 TX state machine. It emits sync header plus payload, one 32-bit half per enabled cycle, to the TX scrambler and gearbox. It is the counterpart of the RX 66/64 decoder and honours the same gearbox clock-enable pacing.

Parameters:
ENC_OUT_REG, 1, 1 = registered outputs (latency below); 0 = no output stage, latency one enabled cycle less.

Ports:
i_clk  in  1  PCS TX clock (single clock domain)
i_reset_n  in  1  asynchronous active-low reset
i_clk_en  in  1  gearbox pause; all state advances only when high
i_xgmii_ctrl  in  N_CHANNELS(4)  per-lane control flag
i_xgmii_data  in  N_CHANNELS x W_BYTE  per-lane byte; lane 0 = bits 7:0
o_hdr_valid  out  1  high on the transfer carrying payload bits 31:0 (first half)
o_hdr  out  W_SYNC(2)  sync header, valid when o_hdr_valid
o_data  out  W_DATA(32)  payload half, unscrambled
o_blk_err  out  1  one-cycle pulse with first half of every emitted error block

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: in_cnt=0, out_cnt=0, state=TX_INIT. o_hdr_valid=1, o_hdr=SYNC_CTRL (2'b10), o_data=32'h0000_001E (idle C block, low half), o_blk_err=0. After reset the output stream is idle C blocks until the first encoded block arrives.
- Pairing: 1-bit in_cnt toggles on each enabled cycle. in_cnt=0 transfer = lanes 0-3 of the block; in_cnt=1 = lanes 4-7. The first half is buffered.
- Encode: on the enabled cycle with in_cnt=1, the 8 ctrl flags and 64 data bits are classified combinationally and the 66-bit result is registered.
- Output: o_data = payload[31:0] with o_hdr_valid=1, then payload[63:32] with o_hdr_valid=0.
- Latency (ENC_OUT_REG=1): block lanes in at enabled cycles k, k+1. Halves out at enabled cycles k+2, k+3. No bubbles.
- i_clk_en=0: all registers and outputs hold; o_blk_err forced 0.
- Classification and payload (bit 0 = type byte LSB; all unused bits/control codes 0 = /I/):
  - D: ctrl=8'h00. hdr=SYNC_DATA (2'b01), payload = data lanes 0-7.
  - C: all ctrl, all bytes SYM_IDLE (0x07). Type 0x1E, codes 0.
  - S0: ctrl=8'h01, lane0=SYM_START (0xFB). Type 0x78, lanes 1-7 in payload[63:8].
  - S4: ctrl=8'h1F, lanes 0-3 idle, lane4=0xFB. Type 0x33, lanes 5-7 in payload[63:40].
  - Tk (k=0..7): lanes <k data, lane k=SYM_TERM (0xFD), lanes >k ctrl idle. Type T0..T7 = 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF. Data bytes follow the type byte; remaining bits 0.
  - E: any other pattern, including SYM_ERR, ordered sets and mixed lanes.
- TX state machine (evaluated per block) and output rule:
  - TX_INIT: C->TX_C, S->TX_D, else TX_E.
  - TX_C: C->TX_C, S->TX_D, else TX_E.
  - TX_D: D->TX_D, T->TX_T, else TX_E.
  - TX_T: C->TX_C, S->TX_D, else TX_E.
  - TX_E: C->TX_C, D->TX_D, T->TX_T, S->TX_D, E->TX_E.
  - Next state TX_E => emit error block: SYNC_CTRL, type 0x1E, eight 7-bit codes 0x1E, plus o_blk_err pulse.
  - Otherwise emit the encoded block.
- Reset mid-block: the half-collected block is discarded; the stream restarts at in_cnt=0 with idle output.
- Header is never 2'b00 or 2'b11.

Decomposition:
- Add to eth_pcs_params package:
  - block type constants C/S0/S4/T0-T7/OS_TYPE
  - SYM_IDLE/START/TERM/ERR
  - CODE_IDLE=7'h00, CODE_ERR=7'h1E
  - SYNC_DATA/SYNC_CTRL
  - tx_state_t enum {TX_INIT,TX_C,TX_D,TX_T,TX_E}
  - blk_class_t enum {BLK_C,BLK_S,BLK_D,BLK_T,BLK_E}
- One sub-module, eth_pcs_64_66_blk_classify: purely combinational classification plus payload build; the FSM and pairing stay in the top.

Test Plan:
- Idle stream: ctrl=4'hF, data=32'h07070707 -> each block hdr=2'b10, o_data 32'h0000001E then 32'h00000000, o_blk_err=0.
- Start lane 0: {ctrl 4'h1, data 32'h555555FB}, then {4'h0, 32'hD5555555} -> hdr=2'b01 not used; hdr=2'b10, o_data 32'h55555578 then 32'hD5555555. Next all-data block -> hdr=2'b01, data verbatim.
- Terminate lane 3 after data: {4'h8, 32'hFDCCBBAA}, {4'hF, 32'h07070707} -> hdr=2'b10, o_data 32'hCCBBAAB4 then 32'h0. Repeat for each k=0..7 with correct type byte.
- Protocol violation: idle block then all-data block -> error block, o_data 32'h1E1E1E1E... per packing, o_blk_err=1 one cycle. A following C block returns to normal idle.
- Stall: i_clk_en low for 3 cycles between halves and mid-output -> outputs frozen; the sequence matches the unstalled run.
- Reset asserted after first half of an S0 block -> outputs immediately at reset values. After release, two idle blocks in -> idle out; no S-block remnant.
